series_accumulator: RTL

Parametrised, self-sequenced successor to the sum-adder datapath/controller pair: one block that latches a bound N from the input bus and accumulates a series term by term, one term per clock. Mode 0 accumulates Σi; mode 1 accumulates Σi², both for i = 1..N. It adds a start/busy/done handshake, configurable operand and accumulator widths, and saturating overflow detection. It sits on the shared 8-bit-class input bus and hands its result to downstream display/compare logic.

---
 rtl/series_accumulator.sv | 114 +++++++++++
 1 files changed

// File: rtl/series_accumulator.sv
// Self-sequenced series accumulator: latches bound N and mode on start, then adds
// one term per clock (i or i*i for i = 1..N) with a saturating, sticky overflow.
//
// state  | meaning
// S_IDLE | waiting for start; dataOut/overflow hold the last job's result
// S_RUN  | one term added per edge, count walks 1..N
// S_DONE | single-cycle done pulse, result valid
module series_accumulator #(
  parameter int N_WIDTH   = 8,
  parameter int SUM_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 mode,
  input  logic [N_WIDTH-1:0]   inBus,
  output logic                 busy,
  output logic                 done,
  output logic                 overflow,
  output logic [N_WIDTH-1:0]   count,
  output logic [SUM_WIDTH-1:0] dataOut
);

  localparam int PW = 2 * N_WIDTH;
  localparam int EW = ((SUM_WIDTH > PW) ? SUM_WIDTH : PW) + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t               state_q, state_d;
  logic [N_WIDTH-1:0]   n_q, n_d;
  logic                 mode_q, mode_d;
  logic [N_WIDTH-1:0]   count_q, count_d;
  logic [SUM_WIDTH-1:0] acc_q, acc_d;
  logic                 ovf_q, ovf_d;

  logic [PW-1:0]        prod;
  logic [EW-1:0]        term_ext;
  logic [EW-1:0]        sum_ext;
  logic                 sat;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      n_q     <= '0;
      mode_q  <= 1'b0;
      count_q <= '0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      mode_q  <= mode_d;
      count_q <= count_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
    end
  end

  // Sum is formed one bit wider than either operand so any carry past SUM_WIDTH is seen.
  always_comb begin
    prod     = {{N_WIDTH{1'b0}}, count_q} * {{N_WIDTH{1'b0}}, count_q};
    term_ext = mode_q ? {{(EW-PW){1'b0}}, prod} : {{(EW-N_WIDTH){1'b0}}, count_q};
    sum_ext  = {{(EW-SUM_WIDTH){1'b0}}, acc_q} + term_ext;
    sat      = |sum_ext[EW-1:SUM_WIDTH];
  end

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    mode_d  = mode_q;
    count_d = count_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          n_d     = inBus;
          mode_d  = mode;
          acc_d   = '0;
          ovf_d   = 1'b0;
          count_d = {{(N_WIDTH-1){1'b0}}, 1'b1};
          state_d = (inBus == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (ovf_q || sat) begin
          acc_d = '1;
          ovf_d = 1'b1;
        end else begin
          acc_d = sum_ext[SUM_WIDTH-1:0];
        end
        // Terminate before incrementing so count never wraps at N = all ones.
        if (count_q == n_q) begin
          state_d = S_DONE;
        end else begin
          count_d = count_q + {{(N_WIDTH-1){1'b0}}, 1'b1};
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy     = (state_q == S_RUN);
  assign done     = (state_q == S_DONE);
  assign overflow = ovf_q;
  assign count    = count_q;
  assign dataOut  = acc_q;

endmodule
